// File: rtl/filter_bram_pkg.sv
// Shared types and constants for the banked filter-weight memory.
package filter_bram_pkg;

    // Loader walks the weight stream into the banks.
    typedef enum logic {
        L_IDLE = 1'b0,
        L_LOAD = 1'b1
    } ld_state_e;

    // Reader issues row addresses, then waits for the pipeline to empty.
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_DRAIN = 2'd2
    } rd_state_e;

    localparam int DEFAULT_NUM_BANKS = 4;
    localparam int BANK_IDX_W        = $clog2(DEFAULT_NUM_BANKS);

    // Bank-index width for an arbitrary bank count (never narrower than 1 bit).
    function automatic int bank_idx_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/filter_bram_bank.sv
// One weight bank: single write port, registered read port, read-first.
module filter_bram_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  bram_rst_i,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; sampling the array before the same-edge write gives read-first.
    always_ff @(posedge clk_i or posedge bram_rst_i) begin
        if (bram_rst_i) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/filter_bram_banked.sv
// Banked filter-weight store: a streaming loader scatters weights across
// NUM_BANKS banks, and an independent reader bursts out whole rows.
//
// Load handshake: a weight beat transfers on a rising edge where both
// ld_valid_i and ld_ready_o are high; ld_data_i must be stable while
// ld_valid_i is high and not yet accepted.
module filter_bram_banked
    import filter_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 4,
    parameter int OUT_REG    = 1
) (
    input  logic                            clk_i,
    input  logic                            bram_rst_i,
    input  logic                            ld_start_i,
    input  logic [ADDR_WIDTH-1:0]           ld_base_addr_i,
    input  logic [ADDR_WIDTH-1:0]           ld_len_i,
    input  logic [DATA_WIDTH-1:0]           ld_data_i,
    input  logic                            ld_valid_i,
    output logic                            ld_ready_o,
    output logic                            ld_done_o,
    input  logic                            rd_start_i,
    input  logic [ADDR_WIDTH-1:0]           rd_base_addr_i,
    input  logic [ADDR_WIDTH-1:0]           rd_len_i,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data_o,
    output logic                            rd_valid_o,
    output logic                            rd_busy_o,
    output logic                            rd_done_o,
    output logic                            dbg_ld_state_o,
    output logic [1:0]                      dbg_rd_state_o
);

    localparam int BW = bank_idx_width(NUM_BANKS);

    // Loader state
    ld_state_e             r_ld_state;
    logic [ADDR_WIDTH-1:0] r_ld_row;
    logic [ADDR_WIDTH-1:0] r_ld_left;
    logic [BW-1:0]         r_ld_bank;
    logic                  r_ld_done;
    logic                  w_ld_fire;
    logic [NUM_BANKS-1:0]  w_we;

    // Reader state
    rd_state_e             r_rd_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_rd_left;
    logic                  w_rd_issue;
    logic                  w_rd_last_issue;
    logic                  r_v1;
    logic                  r_last1;

    logic [NUM_BANKS*DATA_WIDTH-1:0] w_bank_rdata;
    logic [NUM_BANKS*DATA_WIDTH-1:0] w_dout;
    logic                            w_valid_out;
    logic                            w_last_out;

    assign ld_ready_o = (r_ld_state == L_LOAD);
    assign w_ld_fire  = ld_ready_o && ld_valid_i;

    // Loader FSM: beat k goes to bank k mod NUM_BANKS; the row advances once all banks are filled.
    always_ff @(posedge clk_i or posedge bram_rst_i) begin
        if (bram_rst_i) begin
            r_ld_state <= L_IDLE;
            r_ld_row   <= '0;
            r_ld_left  <= '0;
            r_ld_bank  <= '0;
            r_ld_done  <= 1'b0;
        end else begin
            r_ld_done <= 1'b0;
            case (r_ld_state)
                L_IDLE: begin
                    if (ld_start_i && (ld_len_i != '0)) begin
                        r_ld_state <= L_LOAD;
                        r_ld_row   <= ld_base_addr_i;
                        r_ld_left  <= ld_len_i;
                        r_ld_bank  <= '0;
                    end
                end
                L_LOAD: begin
                    if (w_ld_fire) begin
                        if (r_ld_bank == BW'(NUM_BANKS - 1)) begin
                            r_ld_bank <= '0;
                            r_ld_row  <= r_ld_row + 1'b1;
                            if (r_ld_left == ADDR_WIDTH'(1)) begin
                                r_ld_state <= L_IDLE;
                                r_ld_done  <= 1'b1;
                            end else begin
                                r_ld_left <= r_ld_left - 1'b1;
                            end
                        end else begin
                            r_ld_bank <= r_ld_bank + 1'b1;
                        end
                    end
                end
                default: r_ld_state <= L_IDLE;
            endcase
        end
    end

    assign ld_done_o = r_ld_done;

    assign w_rd_issue      = (r_rd_state == R_READ);
    assign w_rd_last_issue = w_rd_issue && (r_rd_left == ADDR_WIDTH'(1));

    // Reader FSM: one row address per cycle, then drain until the last row leaves the pipeline.
    always_ff @(posedge clk_i or posedge bram_rst_i) begin
        if (bram_rst_i) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_left  <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (rd_start_i && (rd_len_i != '0)) begin
                        r_rd_state <= R_READ;
                        r_rd_addr  <= rd_base_addr_i;
                        r_rd_left  <= rd_len_i;
                    end
                end
                R_READ: begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                    r_rd_left <= r_rd_left - 1'b1;
                    if (r_rd_left == ADDR_WIDTH'(1)) begin
                        r_rd_state <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (w_last_out) begin
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // Valid/last tags travelling alongside the bank read registers.
    always_ff @(posedge clk_i or posedge bram_rst_i) begin
        if (bram_rst_i) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            r_v1    <= w_rd_issue;
            r_last1 <= w_rd_last_issue;
        end
    end

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign w_we[b] = w_ld_fire && (r_ld_bank == BW'(b));

            filter_bram_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_bank (
                .clk_i      (clk_i),
                .bram_rst_i (bram_rst_i),
                .i_we       (w_we[b]),
                .i_waddr    (r_ld_row),
                .i_wdata    (ld_data_i),
                .i_re       (w_rd_issue),
                .i_raddr    (r_rd_addr),
                .o_rdata    (w_bank_rdata[b*DATA_WIDTH +: DATA_WIDTH])
            );
        end

        if (OUT_REG != 0) begin : g_out_reg
            logic                            r_v2;
            logic                            r_last2;
            logic [NUM_BANKS*DATA_WIDTH-1:0] r_dout;

            // Extra output stage; the data register only loads on valid rows so it holds otherwise.
            always_ff @(posedge clk_i or posedge bram_rst_i) begin
                if (bram_rst_i) begin
                    r_v2    <= 1'b0;
                    r_last2 <= 1'b0;
                    r_dout  <= '0;
                end else begin
                    r_v2    <= r_v1;
                    r_last2 <= r_last1;
                    if (r_v1) begin
                        r_dout <= w_bank_rdata;
                    end
                end
            end

            assign w_valid_out = r_v2;
            assign w_last_out  = r_last2;
            assign w_dout      = r_dout;
        end else begin : g_no_out_reg
            // Bank read registers only load on issue, so they already hold between rows.
            assign w_valid_out = r_v1;
            assign w_last_out  = r_last1;
            assign w_dout      = w_bank_rdata;
        end
    endgenerate

    assign rd_data_o      = w_dout;
    assign rd_valid_o     = w_valid_out;
    assign rd_done_o      = w_last_out;
    assign rd_busy_o      = (r_rd_state != R_IDLE);
    assign dbg_ld_state_o = r_ld_state;
    assign dbg_rd_state_o = r_rd_state;

endmodule

// File: tb/tb_filter_bram_banked.sv
// Directed bench for filter_bram_banked (16-bit weights, 16 rows, 4 banks, output register on).
module tb_filter_bram_banked;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NB = 4;
    localparam int RW = NB * DW;

    // Clock / reset
    logic clk = 1'b0;
    logic bram_rst_i = 1'b0;
    always #5 clk = ~clk;

    logic          ld_start_i = 1'b0;
    logic [AW-1:0] ld_base_addr_i = '0;
    logic [AW-1:0] ld_len_i = '0;
    logic [DW-1:0] ld_data_i = '0;
    logic          ld_valid_i = 1'b0;
    logic          ld_ready_o;
    logic          ld_done_o;
    logic          rd_start_i = 1'b0;
    logic [AW-1:0] rd_base_addr_i = '0;
    logic [AW-1:0] rd_len_i = '0;
    logic [RW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          rd_busy_o;
    logic          rd_done_o;
    logic          dbg_ld_state_o;
    logic [1:0]    dbg_rd_state_o;

    filter_bram_banked #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_BANKS  (NB),
        .OUT_REG    (1)
    ) dut (
        .clk_i          (clk),
        .bram_rst_i     (bram_rst_i),
        .ld_start_i     (ld_start_i),
        .ld_base_addr_i (ld_base_addr_i),
        .ld_len_i       (ld_len_i),
        .ld_data_i      (ld_data_i),
        .ld_valid_i     (ld_valid_i),
        .ld_ready_o     (ld_ready_o),
        .ld_done_o      (ld_done_o),
        .rd_start_i     (rd_start_i),
        .rd_base_addr_i (rd_base_addr_i),
        .rd_len_i       (rd_len_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .rd_busy_o      (rd_busy_o),
        .rd_done_o      (rd_done_o),
        .dbg_ld_state_o (dbg_ld_state_o),
        .dbg_rd_state_o (dbg_rd_state_o)
    );

    // Scoreboard
    int            n_assert = 0;
    int            n_fail = 0;
    logic [RW-1:0] exp_q[$];
    logic [DW-1:0] ld_q[$];

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: load ld_q beats as len rows at base; optionally insert an idle cycle before each beat.
    task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] len, input bit toggle);
        int n;
        n = ld_q.size();
        @(negedge clk);
        ld_start_i = 1'b1; ld_base_addr_i = base; ld_len_i = len;
        @(negedge clk);
        ld_start_i = 1'b0;
        check("ld_ready_start", ld_ready_o, 1);
        for (int k = 0; k < n; k++) begin
            if (toggle) begin
                ld_valid_i = 1'b0; ld_data_i = 16'hDEAD;
                @(negedge clk);
                check("ld_ready_gap", ld_ready_o, 1);
            end
            ld_valid_i = 1'b1; ld_data_i = ld_q.pop_front();
            @(negedge clk);
            if (k != n - 1) check("ld_done_early", ld_done_o, 0);
        end
        ld_valid_i = 1'b0;
        check("ld_done_pulse", ld_done_o, 1);
        check("ld_ready_after", ld_ready_o, 0);
        @(negedge clk);
        check("ld_done_clear", ld_done_o, 0);
    endtask

    // Driver + checker: read len rows from base against exp_q; optional second start while busy.
    task automatic do_read(input logic [AW-1:0] base, input logic [AW-1:0] len, input bit restart);
        logic [RW-1:0] last;
        last = '0;
        @(negedge clk);
        rd_start_i = 1'b1; rd_base_addr_i = base; rd_len_i = len;
        @(negedge clk);
        if (restart) begin
            rd_base_addr_i = 4'd0; rd_len_i = 4'd3;
        end else begin
            rd_start_i = 1'b0;
        end
        check("rd_busy", rd_busy_o, 1);
        check("rd_lat0", rd_valid_o, 0);
        @(negedge clk);
        rd_start_i = 1'b0;
        check("rd_lat1", rd_valid_o, 0);
        for (int i = 0; i < int'(len); i++) begin
            @(negedge clk);
            last = exp_q.pop_front();
            check("rd_valid", rd_valid_o, 1);
            check("rd_row", rd_data_o, last);
            check("rd_done", rd_done_o, (i == int'(len) - 1) ? 1 : 0);
        end
        @(negedge clk);
        check("rd_valid_end", rd_valid_o, 0);
        check("rd_done_end", rd_done_o, 0);
        check("rd_busy_end", rd_busy_o, 0);
        check("rd_hold", rd_data_o, last);
        @(negedge clk);
        check("rd_valid_quiet", rd_valid_o, 0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2 bram_rst_i = 1'b1;
        @(negedge clk);
        check("rst_ld_ready", ld_ready_o, 0);
        check("rst_ld_done", ld_done_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_busy", rd_busy_o, 0);
        check("rst_rd_done", rd_done_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_ld_state", dbg_ld_state_o, 0);
        check("rst_rd_state", dbg_rd_state_o, 0);
        @(negedge clk);
        bram_rst_i = 1'b0;

        // Load rows 2..3 with 1..8, read back (bank0 in low bits)
        for (int k = 1; k <= 8; k++) ld_q.push_back(DW'(k));
        do_load(4'd2, 4'd2, 1'b0);
        exp_q.push_back(64'h0004_0003_0002_0001);
        exp_q.push_back(64'h0008_0007_0006_0005);
        do_read(4'd2, 4'd2, 1'b0);

        // Wrapping load with gaps between beats, wrapping read
        for (int k = 1; k <= 8; k++) ld_q.push_back(16'h00A0 + DW'(k));
        do_load(4'd15, 4'd2, 1'b1);
        exp_q.push_back(64'h00A4_00A3_00A2_00A1);
        exp_q.push_back(64'h00A8_00A7_00A6_00A5);
        do_read(4'd15, 4'd2, 1'b0);

        // Zero-length read start is ignored
        @(negedge clk);
        rd_start_i = 1'b1; rd_base_addr_i = 4'd3; rd_len_i = 4'd0;
        @(negedge clk);
        rd_start_i = 1'b0;
        check("len0_busy", rd_busy_o, 0);
        check("len0_state", dbg_rd_state_o, 0);
        @(negedge clk);
        @(negedge clk);
        check("len0_valid", rd_valid_o, 0);

        // Second start while busy is ignored
        exp_q.push_back(64'h0004_0003_0002_0001);
        exp_q.push_back(64'h0008_0007_0006_0005);
        do_read(4'd2, 4'd2, 1'b1);

        // Preload row 7, then reset in the middle of a reload of row 7 while a read is in flight
        ld_q.push_back(16'h7770); ld_q.push_back(16'h7771);
        ld_q.push_back(16'h7772); ld_q.push_back(16'h7773);
        do_load(4'd7, 4'd1, 1'b0);
        @(negedge clk);
        ld_start_i = 1'b1; ld_base_addr_i = 4'd7; ld_len_i = 4'd1;
        rd_start_i = 1'b1; rd_base_addr_i = 4'd2; rd_len_i = 4'd2;
        @(negedge clk);
        ld_start_i = 1'b0; rd_start_i = 1'b0;
        check("conc_ld_ready", ld_ready_o, 1);
        check("conc_rd_busy", rd_busy_o, 1);
        ld_valid_i = 1'b1; ld_data_i = 16'h0C01;
        @(negedge clk);
        ld_data_i = 16'h0C02;
        @(negedge clk);
        ld_data_i = 16'h0C03;
        check("conc_rd_row0", rd_data_o, 64'h0004_0003_0002_0001);
        @(negedge clk);
        ld_valid_i = 1'b0;
        check("pre_rst_rd_valid", rd_valid_o, 1);
        check("pre_rst_rd_done", rd_done_o, 1);
        check("pre_rst_ld_ready", ld_ready_o, 1);
        #2 bram_rst_i = 1'b1;
        #1;
        check("arst_ld_ready", ld_ready_o, 0);
        check("arst_ld_done", ld_done_o, 0);
        check("arst_rd_valid", rd_valid_o, 0);
        check("arst_rd_busy", rd_busy_o, 0);
        check("arst_rd_done", rd_done_o, 0);
        check("arst_rd_data", rd_data_o, 0);
        check("arst_ld_state", dbg_ld_state_o, 0);
        @(negedge clk);
        bram_rst_i = 1'b0;
        exp_q.push_back(64'h7773_0C03_0C02_0C01);
        do_read(4'd7, 4'd1, 1'b0);
        ld_q.push_back(16'h0D01); ld_q.push_back(16'h0D02);
        ld_q.push_back(16'h0D03); ld_q.push_back(16'h0D04);
        do_load(4'd7, 4'd1, 1'b0);
        exp_q.push_back(64'h0D04_0D03_0D02_0D01);
        do_read(4'd7, 4'd1, 1'b0);

        // Read-first: bank1 row5 written with BEEF on the same edge it is read
        ld_q.push_back(16'h1000); ld_q.push_back(16'h1111);
        ld_q.push_back(16'h2222); ld_q.push_back(16'h3333);
        do_load(4'd5, 4'd1, 1'b0);
        @(negedge clk);
        ld_start_i = 1'b1; ld_base_addr_i = 4'd5; ld_len_i = 4'd1;
        @(negedge clk);
        ld_start_i = 1'b0;
        ld_valid_i = 1'b1; ld_data_i = 16'h5000;
        rd_start_i = 1'b1; rd_base_addr_i = 4'd5; rd_len_i = 4'd1;
        @(negedge clk);
        rd_start_i = 1'b0;
        ld_data_i = 16'hBEEF;
        @(negedge clk);
        ld_data_i = 16'h6000;
        @(negedge clk);
        ld_data_i = 16'h7000;
        check("rf_valid", rd_valid_o, 1);
        check("rf_row_old", rd_data_o, 64'h3333_2222_1111_5000);
        check("rf_done", rd_done_o, 1);
        @(negedge clk);
        ld_valid_i = 1'b0;
        check("rf_ld_done", ld_done_o, 1);
        check("rf_valid_end", rd_valid_o, 0);
        exp_q.push_back(64'h7000_6000_BEEF_5000);
        do_read(4'd5, 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_bram_banked.md
FILTER_BRAM_BANKED -- requirements
Module: filter_bram_banked

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one filter weight.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, row address width; depth per bank = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_BANKS, default 4, number of parallel banks (power of two, >=2).
REQ-004 SHALL have parameter OUT_REG, default 1; 0 or 1 extra output register stage.
REQ-005 SHALL have port clk_i, input, 1 bit, clock, all logic on rising edge.
REQ-006 SHALL have port bram_rst_i, input, 1 bit, reset, asynchronous, active-high.
REQ-007 SHALL have port ld_start_i, input, 1 bit, load-start pulse.
REQ-008 SHALL have port ld_base_addr_i, input, ADDR_WIDTH bits, first row written.
REQ-009 SHALL have port ld_len_i, input, ADDR_WIDTH bits, rows to load; 0 = start ignored.
REQ-010 SHALL have port ld_data_i, input, DATA_WIDTH bits, weight stream.
REQ-011 SHALL have port ld_valid_i, input, 1 bit, weight valid.
REQ-012 SHALL have port ld_ready_o, output, 1 bit, loader accepts weight.
REQ-013 SHALL have port ld_done_o, output, 1 bit, one-cycle pulse, load complete.
REQ-014 SHALL have port rd_start_i, input, 1 bit, read-burst start pulse.
REQ-015 SHALL have port rd_base_addr_i, input, ADDR_WIDTH bits, first row read.
REQ-016 SHALL have port rd_len_i, input, ADDR_WIDTH bits, rows to read; 0 = start ignored.
REQ-017 SHALL have port rd_data_o, output, NUM_BANKS*DATA_WIDTH bits, one row; bank b at bits [b*DATA_WIDTH +: DATA_WIDTH].
REQ-018 SHALL have port rd_valid_o, output, 1 bit, rd_data_o valid.
REQ-019 SHALL have port rd_busy_o, output, 1 bit, reader not IDLE.
REQ-020 SHALL have port rd_done_o, output, 1 bit, one-cycle pulse with last valid row.

Function
REQ-021 Loader FSM SHALL have states L_IDLE, L_LOAD; L_IDLE->L_LOAD on ld_start_i with ld_len_i!=0; L_LOAD->L_IDLE after last beat.
REQ-022 ld_ready_o SHALL be high exactly in L_LOAD; beat accepted when ld_valid_i&ld_ready_o.
REQ-023 Beat k (from 0) SHALL write bank k mod NUM_BANKS, row (ld_base_addr_i + k/NUM_BANKS) mod 2**ADDR_WIDTH; ld_len_i*NUM_BANKS beats total.
REQ-024 ld_done_o SHALL pulse the cycle after the last accepted beat; ld_start_i in L_LOAD SHALL be ignored.
REQ-025 Reader FSM SHALL have states R_IDLE, R_READ, R_DRAIN; R_IDLE->R_READ on rd_start_i with rd_len_i!=0; issues one row address per cycle, rows wrap modulo 2**ADDR_WIDTH.
REQ-026 R_READ->R_DRAIN after issuing the last row; R_DRAIN->R_IDLE when the last row is output; rd_start_i ignored unless R_IDLE.
REQ-027 Read latency SHALL be 1+OUT_REG cycles from address issue to rd_valid_o; rows output consecutively, rd_valid_o high for exactly rd_len_i cycles.
REQ-028 rd_data_o SHALL hold its last value when rd_valid_o is low.
REQ-029 Loader and reader SHALL run independently and concurrently; simultaneous ld_start_i and rd_start_i both accepted.
REQ-030 Same bank/row written and read in one cycle SHALL return old data (read-first).

Reset
REQ-031 bram_rst_i SHALL force both FSMs to IDLE and ld_ready_o, ld_done_o, rd_valid_o, rd_busy_o, rd_done_o, rd_data_o to 0, including mid-operation.
REQ-032 Memory contents SHALL NOT be cleared by reset; an aborted load leaves already-written words in place.

Structure
REQ-033 Package filter_bram_pkg SHALL hold loader/reader state enums and bank-index width constant (clog2 NUM_BANKS).
REQ-034 Sub-module filter_bram_bank (one write port, one registered read port, read-first) SHALL be instantiated NUM_BANKS times.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4, NUM_BANKS=4, OUT_REG=1)
REQ-035 Load base 2, len 2, beats 0x0001..0x0008 -> bank0 row2=0x0001, bank3 row3=0x0008, ld_done_o one cycle after beat 8.
REQ-036 Read base 2, len 2 -> rd_valid_o 2 cycles after start+1 issue, rows {0x0004,0x0003,0x0002,0x0001},{0x0008,..,0x0005}, rd_done_o on second.
REQ-037 Load base 15, len 2 with ld_valid_i toggling every cycle -> second row lands at row 0, 8 beats accepted only when valid.
REQ-038 rd_start_i with len 0, and second rd_start_i while busy -> no state change, rd_valid_o count unchanged.
REQ-039 Assert bram_rst_i after 3 load beats -> all outputs 0 asynchronously, first 3 words retained, new load accepted after release.
REQ-040 Write 0xBEEF to bank1 row5 while reading row5 (old 0x1111) -> read returns 0x1111, next read 0xBEEF.
